// File: rtl/jtag_shift_master.sv
// Wishbone-controlled JTAG master: shifts up to 32 TMS/TDI bits LSB first on a
// divided TCK and captures TDO into a right-justified register.
module jtag_shift_master #(
  parameter int DIV = 2
) (
  input  logic        wb_clk,
  input  logic        wb_rstn,
  input  logic [1:0]  i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_jtag_tck,
  output logic        o_jtag_tms,
  output logic        o_jtag_tdi,
  input  logic        i_jtag_tdo,
  output logic        o_jtag_trst,
  output logic        o_busy
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  state_t      r_state, w_nextState;
  logic [7:0]  r_divCnt;
  logic [5:0]  r_len;
  logic [5:0]  r_idx;
  logic [31:0] r_tmsVec, r_tdiVec, r_tdo;
  logic [31:0] r_tmsSr, r_tdiSr;
  logic        r_tms, r_tdi, r_tck, r_trst, r_done, r_ack;
  logic [31:0] r_rdt;

  logic        w_phaseEnd, w_wrCommit, w_ctrlWr, w_start, w_lastBit, w_idle;
  logic [5:0]  w_lenEff;
  logic [31:0] w_rdData;

  assign w_idle     = (r_state == IDLE);
  assign w_phaseEnd = (r_divCnt == 8'(DIV - 1));
  // Writes commit on the ack cycle, so a start enters LOW one cycle after the ack.
  assign w_wrCommit = i_wb_cyc & i_wb_we & r_ack;
  assign w_ctrlWr   = w_wrCommit && (i_wb_adr == 2'd0);
  assign w_start    = w_ctrlWr && i_wb_dat[8] && w_idle;
  assign w_lenEff   = ((r_len == 6'd0) || (r_len > 6'd32)) ? 6'd32 : r_len;
  assign w_lastBit  = ((r_idx + 6'd1) == w_lenEff);

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: if (w_start) w_nextState = LOW;
      LOW:  if (w_phaseEnd) w_nextState = HIGH;
      HIGH: if (w_phaseEnd) w_nextState = w_lastBit ? IDLE : LOW;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (!wb_rstn) r_state <= IDLE;
    else          r_state <= w_nextState;
  end

  always_comb begin
    w_rdData = 32'd0;
    case (i_wb_adr)
      2'd0: w_rdData = {15'd0, r_trst, 2'd0, r_len, 6'd0, r_done, ~w_idle};
      2'd1: w_rdData = r_tmsVec;
      2'd2: w_rdData = r_tdiVec;
      2'd3: w_rdData = r_tdo;
      default: w_rdData = 32'd0;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (!wb_rstn) begin
      r_ack    <= 1'b0;
      r_rdt    <= 32'd0;
      r_trst   <= 1'b0;
      r_len    <= 6'd0;
      r_idx    <= 6'd0;
      r_divCnt <= 8'd0;
      r_tmsVec <= 32'd0;
      r_tdiVec <= 32'd0;
      r_tdo    <= 32'd0;
      r_tmsSr  <= 32'd0;
      r_tdiSr  <= 32'd0;
      r_tms    <= 1'b0;
      r_tdi    <= 1'b0;
      r_tck    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_ack <= i_wb_cyc & ~r_ack;
      if (i_wb_cyc & ~r_ack) r_rdt <= w_rdData;

      if (w_ctrlWr) r_trst <= i_wb_dat[9];
      if (w_wrCommit && w_idle && (i_wb_adr == 2'd1)) r_tmsVec <= i_wb_dat;
      if (w_wrCommit && w_idle && (i_wb_adr == 2'd2)) r_tdiVec <= i_wb_dat;

      if (!w_idle) r_divCnt <= w_phaseEnd ? 8'd0 : r_divCnt + 8'd1;

      if (w_start) begin
        r_len    <= i_wb_dat[5:0];
        r_idx    <= 6'd0;
        r_divCnt <= 8'd0;
        r_tmsSr  <= r_tmsVec;
        r_tdiSr  <= r_tdiVec;
        r_tms    <= r_tmsVec[0];
        r_tdi    <= r_tdiVec[0];
        r_tdo    <= 32'd0;
        r_done   <= 1'b0;
      end

      if ((r_state == LOW) && w_phaseEnd) begin
        r_tdo[r_idx[4:0]] <= i_jtag_tdo;
        r_tck             <= 1'b1;
      end

      // TMS/TDI stay on the last driven bit once the command finishes.
      if ((r_state == HIGH) && w_phaseEnd) begin
        r_tck   <= 1'b0;
        r_tmsSr <= {1'b0, r_tmsSr[31:1]};
        r_tdiSr <= {1'b0, r_tdiSr[31:1]};
        r_idx   <= r_idx + 6'd1;
        if (w_lastBit) begin
          r_done <= 1'b1;
        end else begin
          r_tms <= r_tmsSr[1];
          r_tdi <= r_tdiSr[1];
        end
      end
    end
  end

  assign o_wb_ack    = r_ack;
  assign o_wb_rdt    = r_rdt;
  assign o_jtag_tck  = r_tck;
  assign o_jtag_tms  = r_tms;
  assign o_jtag_tdi  = r_tdi;
  assign o_jtag_trst = r_trst;
  assign o_busy      = ~w_idle;

endmodule

// File: doc/jtag_shift_master.md
Name: jtag_shift_master

Overview:
- Wishbone-slave-controlled JTAG master that generates TCK/TMS/TDI and captures TDO.
- It is the initiator end of the JTAG link whose responder is the on-chip debug DTM.
- Used for on-chip self-test of the DTM/TAP path (loopback into the debug transport) and for driving external TAPs from CPU firmware via dbus.
- Shifts up to 32 bits per command, LSB first, at a TCK rate set by a divider.

Parameters:
- DIV, 2, TCK half-period in wb_clk cycles (legal range 1..255).

Ports:
- wb_clk  input  1  system clock; the only clock.
- wb_rstn  input  1  synchronous reset, active low.
- i_wb_adr  input  2  word select (CPU byte address bits [3:2]).
- i_wb_dat  input  32  write data.
- i_wb_we  input  1  write enable.
- i_wb_cyc  input  1  cycle/strobe.
- o_wb_rdt  output  32  read data.
- o_wb_ack  output  1  transfer acknowledge.
- o_jtag_tck  output  1  JTAG TCK.
- o_jtag_tms  output  1  JTAG TMS.
- o_jtag_tdi  output  1  JTAG TDI.
- i_jtag_tdo  input  1  JTAG TDO.
- o_jtag_trst  output  1  JTAG TRST, driven directly from the CTRL register.
- o_busy  output  1  shift in progress.

Behaviour:
- Reset: on a wb_clk edge with wb_rstn=0, the block resets synchronously.
  - All outputs are 0.
  - TMS, TDI, TDO and CTRL registers are 0.
  - done=0; FSM goes to IDLE.
  - Reset mid-shift aborts immediately: TCK low, busy 0, done stays 0.
- Wishbone:
  - o_wb_ack is registered: it pulses 1 cycle after i_wb_cyc is sampled high, then is forced low for one cycle, so there is 1 ack per transfer.
  - Reads are valid with the ack.
  - Byte selects are not supported; writes are full-word.
- Register map (i_wb_adr):
  - 0 CTRL (write):
    - [5:0] len; 0 means 32.
    - [8] start.
    - [9] trst.
  - 0 STATUS (read):
    - [0] busy.
    - [1] done.
    - [13:8] len.
    - [16] trst.
  - 1 TMS vector (R/W).
  - 2 TDI vector (R/W).
  - 3 TDO capture (RO).
- Writes while busy:
  - Writes to addresses 1/2 and len/start are ignored but still acked.
  - The trst bit is always written.
  - A start while busy is ignored.
- Start (CTRL write, start=1, not busy):
  - Latch len; load shift registers from TMS/TDI; clear TDO capture; clear done.
  - Set bit index to 0.
  - Enter LOW on the cycle after the ack cycle; busy reads 1 from that cycle.
- FSM states: IDLE, LOW, HIGH. A divider counter counts DIV cycles per phase.
  - LOW: TCK=0.
    - o_jtag_tms = tms_sr[0] and o_jtag_tdi = tdi_sr[0], registered and stable for the whole phase.
    - After DIV cycles go to HIGH.
    - On the edge that raises TCK, sample i_jtag_tdo into tdo[index].
  - HIGH: TCK=1 for DIV cycles.
    - At exit, shift tms_sr/tdi_sr right by 1 and increment index.
    - If index+1 == len, go to IDLE, set done=1, busy=0.
    - Otherwise go to LOW.
- Timing: a len-bit command keeps busy high for exactly 2*DIV*len wb_clk cycles and produces exactly len TCK rising edges.
- IDLE outputs:
  - TCK=0.
  - TMS/TDI hold the last driven value.
- TMS/TDI registers (addresses 1/2) are not modified by shifting; a read returns the written value.
- TDO register holds the captured bits right-justified: bit i is the i-th sampled TDO. Bits at and above len are 0.
- done is sticky until the next accepted start or reset.

Test Plan:
- Reset with DIV=2:
  - Stimulus: assert wb_rstn=0 for 2 cycles.
  - Required: tck/tms/tdi/trst/busy/ack = 0; reads of addresses 0..3 return 0.
- TMS sequence:
  - Stimulus: write TMS=0x0000001F, TDI=0, CTRL=0x105 (len 5, start).
  - Required:
    - exactly 5 TCK pulses, each 2 cycles low and 2 cycles high;
    - TMS=1 on all 5 pulses;
    - busy for 20 cycles;
    - STATUS then reads 0x00000502.
- Loopback, len 8:
  - Stimulus: tie i_jtag_tdo to o_jtag_tdi; TDI=0xA5; start len 8.
  - Required: TDO reads 0x000000A5 and done=1.
- Loopback, len 0 (means 32):
  - Stimulus: TDI=0xDEADBEEF; start with len=0.
  - Required: 32 TCK pulses; busy for 128 cycles; TDO reads 0xDEADBEEF.
- Writes while busy:
  - Stimulus: during a busy shift, write TDI=0x12345678 and CTRL=0x308.
  - Required:
    - both writes are acked;
    - TDI readback is unchanged;
    - the shift continues with the original length;
    - o_jtag_trst goes to 1 immediately.
- Reset mid-shift:
  - Stimulus: deassert wb_rstn for 1 cycle at bit 3 of an 8-bit shift.
  - Required:
    - next cycle TCK=0 and busy=0;
    - STATUS=0 and TDO=0;
    - no further TCK edges.
